reg_file_sb: RTL and testbench

Parametrised multi-read-port integer register file with a built-in pending-write scoreboard for the single-cycle RISC-V core and its multicycle-load successor. It provides NREAD combinational read ports with a hardwired zero register and write-to-read bypass. A per-register busy bit is set when a long-latency instruction issues and cleared when that instruction writes back, so the decode stage can stall on operand hazards.

---
 rtl/reg_file_sb.sv | 84 ++++++++
 tb/tb_reg_file_sb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with a pending-write scoreboard.
//   Register 0 is hardwired to zero. Reads are combinational, and the writeback
//   port bypasses to any read port that addresses the register being written.
//   A busy bit per register is set when a long-latency producer issues
//   (sb_set/sb_addr) and cleared by that register's writeback.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   regwrite, rd,     writeback port (rd = 0 is a no-op)
//   write_data
//   raddr             NREAD packed read addresses, port i at [i*AW +: AW]
//   read_data         NREAD packed read data, port i at [i*XLEN +: XLEN]
//   sb_set, sb_addr   mark a register pending (sb_addr = 0 ignored)
//   rd_busy           per-port operand hazard flag
//   busy_vec          raw scoreboard state
module reg_file_sb #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned NREAD = 2,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    regwrite,
    input  logic [AW-1:0]           rd,
    input  logic [XLEN-1:0]         write_data,
    input  logic [NREAD*AW-1:0]     raddr,
    output logic [NREAD*XLEN-1:0]   read_data,
    input  logic                    sb_set,
    input  logic [AW-1:0]           sb_addr,
    output logic [NREAD-1:0]        rd_busy,
    output logic [NREG-1:0]         busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy_q;

    // Register storage; entry 0 is only ever loaded with zero at reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (regwrite && (rd != '0)) begin
            regs[rd] <= write_data;
        end
    end

    // Scoreboard: a new issue to the same register wins over its writeback.
    always_ff @(posedge clk) begin
        busy_q[0] <= 1'b0;
        if (reset) begin
            busy_q <= '0;
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (sb_set && (sb_addr == AW'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (regwrite && (rd == AW'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy_q;

    // Read ports: zero register, then writeback bypass, then storage.
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] addr;
        logic          hit;
        logic          nonzero;

        assign addr    = raddr[p*AW +: AW];
        assign nonzero = (addr != '0);
        assign hit     = regwrite && (rd == addr);

        assign read_data[p*XLEN +: XLEN] = !nonzero ? '0 :
                                           hit      ? write_data :
                                                      regs[addr];

        // A writeback in this cycle resolves the hazard through the bypass.
        assign rd_busy[p] = nonzero && busy_q[addr] && !hit;
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic on a default instance, and a 64-bit / 16-entry / 3-port instance.
module tb_reg_file_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic        a_reset, a_regwrite, a_sb_set;
    logic [4:0]  a_rd, a_sb_addr;
    logic [31:0] a_wd;
    logic [9:0]  a_raddr;
    logic [63:0] a_read_data;
    logic [1:0]  a_rd_busy;
    logic [31:0] a_busy_vec;

    reg_file_sb u_a (
        .clk(clk), .reset(a_reset), .regwrite(a_regwrite), .rd(a_rd),
        .write_data(a_wd), .raddr(a_raddr), .read_data(a_read_data),
        .sb_set(a_sb_set), .sb_addr(a_sb_addr), .rd_busy(a_rd_busy),
        .busy_vec(a_busy_vec)
    );

    // Instance B: NREG=16, NREAD=3, XLEN=64
    logic         b_reset, b_regwrite, b_sb_set;
    logic [3:0]   b_rd, b_sb_addr;
    logic [63:0]  b_wd;
    logic [11:0]  b_raddr;
    logic [191:0] b_read_data;
    logic [2:0]   b_rd_busy;
    logic [15:0]  b_busy_vec;

    reg_file_sb #(.XLEN(64), .NREG(16), .NREAD(3)) u_b (
        .clk(clk), .reset(b_reset), .regwrite(b_regwrite), .rd(b_rd),
        .write_data(b_wd), .raddr(b_raddr), .read_data(b_read_data),
        .sb_set(b_sb_set), .sb_addr(b_sb_addr), .rd_busy(b_rd_busy),
        .busy_vec(b_busy_vec)
    );

    // Reference model of instance A architectural state
    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one edge; the model applies the rules to the inputs present at the edge.
    task automatic step();
        @(posedge clk);
        if (a_reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_busy = '0;
        end else begin
            if (a_regwrite && a_rd != 5'd0) begin
                m_regs[a_rd] = a_wd;
                m_busy[a_rd] = 1'b0;
            end
            if (a_sb_set && a_sb_addr != 5'd0) m_busy[a_sb_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    // Compare every output of instance A against the model.
    task automatic check_a(input string tag);
        logic [4:0]  ad;
        logic [31:0] ed;
        logic        eb;
        #1;
        for (int p = 0; p < 2; p++) begin
            ad = a_raddr[p*5 +: 5];
            if (ad == 5'd0)                         ed = '0;
            else if (a_regwrite && a_rd == ad)      ed = a_wd;
            else                                    ed = m_regs[ad];
            eb = (ad != 5'd0) && m_busy[ad] && !(a_regwrite && a_rd == ad);
            chk($sformatf("%s rdata%0d", tag, p), {32'd0, a_read_data[p*32 +: 32]}, {32'd0, ed});
            chk($sformatf("%s rbusy%0d", tag, p), {63'd0, a_rd_busy[p]}, {63'd0, eb});
        end
        chk($sformatf("%s busy_vec", tag), {32'd0, a_busy_vec}, {32'd0, m_busy});
    endtask

    function automatic logic [63:0] bval(input int i);
        return {32'hA000_0000 | 32'(i), 32'(i) * 32'h0101_0101};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        b_reset = 1'b1; b_regwrite = 1'b0; b_sb_set = 1'b0;
        b_rd = '0; b_sb_addr = '0; b_wd = '0; b_raddr = '0;

        // Reset overrides a concurrent write
        a_reset = 1'b1; a_regwrite = 1'b1; a_rd = 5'd5; a_wd = 32'hDEADBEEF;
        a_raddr = {5'd5, 5'd5}; a_sb_set = 1'b0; a_sb_addr = '0;
        step();
        a_reset = 1'b0; a_regwrite = 1'b0;
        check_a("reset");
        chk("reset x5 p0", {32'd0, a_read_data[31:0]}, 64'd0);
        chk("reset x5 p1", {32'd0, a_read_data[63:32]}, 64'd0);
        chk("reset busy_vec", {32'd0, a_busy_vec}, 64'd0);

        // x0 protection
        a_regwrite = 1'b1; a_rd = 5'd0; a_wd = 32'hFFFFFFFF;
        a_sb_set = 1'b1; a_sb_addr = 5'd0; a_raddr = '0;
        check_a("x0 same");
        chk("x0 p0", {32'd0, a_read_data[31:0]}, 64'd0);
        step();
        a_regwrite = 1'b0; a_sb_set = 1'b0;
        check_a("x0 next");
        chk("x0 busy0", {63'd0, a_busy_vec[0]}, 64'd0);

        // Bypass then stored value
        a_regwrite = 1'b1; a_rd = 5'd7; a_wd = 32'h12345678; a_raddr = {5'd7, 5'd7};
        check_a("bypass");
        chk("bypass p0", {32'd0, a_read_data[31:0]}, 64'h12345678);
        chk("bypass p1", {32'd0, a_read_data[63:32]}, 64'h12345678);
        step();
        a_regwrite = 1'b0;
        check_a("stored");
        chk("stored p1", {32'd0, a_read_data[63:32]}, 64'h12345678);

        // Scoreboard lifecycle on x10
        a_sb_set = 1'b1; a_sb_addr = 5'd10; a_raddr = {5'd7, 5'd10};
        check_a("sb issue");
        chk("sb no comb path", {63'd0, a_rd_busy[0]}, 64'd0);
        step();
        a_sb_set = 1'b0;
        check_a("sb pending");
        chk("sb rd_busy0", {63'd0, a_rd_busy[0]}, 64'd1);
        chk("sb busy10", {63'd0, a_busy_vec[10]}, 64'd1);
        a_regwrite = 1'b1; a_rd = 5'd10; a_wd = 32'hA5;
        check_a("sb wb");
        chk("sb wb rd_busy0", {63'd0, a_rd_busy[0]}, 64'd0);
        chk("sb wb rdata0", {32'd0, a_read_data[31:0]}, 64'hA5);
        chk("sb wb busy10 still", {63'd0, a_busy_vec[10]}, 64'd1);
        step();
        a_regwrite = 1'b0;
        check_a("sb cleared");
        chk("sb busy10 clear", {63'd0, a_busy_vec[10]}, 64'd0);

        // Simultaneous set and clear
        a_sb_set = 1'b1; a_sb_addr = 5'd3; a_raddr = {5'd4, 5'd3};
        step();
        a_sb_set = 1'b0;
        check_a("x3 set");
        a_sb_set = 1'b1; a_sb_addr = 5'd3; a_regwrite = 1'b1; a_rd = 5'd3; a_wd = 32'h33;
        check_a("x3 set+wb");
        step();
        a_sb_set = 1'b0; a_regwrite = 1'b0;
        check_a("x3 set wins");
        chk("set wins busy3", {63'd0, a_busy_vec[3]}, 64'd1);
        a_sb_set = 1'b1; a_sb_addr = 5'd4; a_regwrite = 1'b1; a_rd = 5'd3; a_wd = 32'h44;
        step();
        a_sb_set = 1'b0; a_regwrite = 1'b0;
        check_a("split set/clr");
        chk("split busy3", {63'd0, a_busy_vec[3]}, 64'd0);
        chk("split busy4", {63'd0, a_busy_vec[4]}, 64'd1);

        // Randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            a_reset    = ($urandom_range(0, 63) == 0);
            a_regwrite = $urandom_range(0, 1) == 1;
            a_rd       = 5'($urandom);
            a_wd       = $urandom;
            a_sb_set   = $urandom_range(0, 2) == 0;
            a_sb_addr  = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom);
            for (int p = 0; p < 2; p++)
                a_raddr[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? a_rd : 5'($urandom);
            check_a($sformatf("rand%0d", it));
            step();
        end
        a_reset = 1'b0; a_regwrite = 1'b0; a_sb_set = 1'b0;

        // Wide instance: fill x1..x15 and read back on three ports
        b_reset = 1'b0;
        for (int i = 1; i < 16; i++) begin
            b_regwrite = 1'b1; b_rd = 4'(i); b_wd = bval(i);
            step();
        end
        b_regwrite = 1'b0;
        #1;
        chk("b busy_vec", {48'd0, b_busy_vec}, 64'd0);
        for (int k = 0; k < 15; k++) begin
            int a0, a1, a2;
            a0 = k + 1;
            a1 = ((k + 5) % 15) + 1;
            a2 = ((k + 10) % 15) + 1;
            b_raddr = {4'(a2), 4'(a1), 4'(a0)};
            #1;
            chk($sformatf("b k%0d p0", k), b_read_data[63:0],    bval(a0));
            chk($sformatf("b k%0d p1", k), b_read_data[127:64],  bval(a1));
            chk($sformatf("b k%0d p2", k), b_read_data[191:128], bval(a2));
            chk($sformatf("b k%0d busy", k), {61'd0, b_rd_busy}, 64'd0);
        end
        b_raddr = {4'd9, 4'd0, 4'd9};
        b_regwrite = 1'b1; b_rd = 4'd9; b_wd = 64'hFEDC_BA98_7654_3210;
        #1;
        chk("b bypass p0", b_read_data[63:0], 64'hFEDC_BA98_7654_3210);
        chk("b x0 p1", b_read_data[127:64], 64'd0);
        chk("b bypass p2", b_read_data[191:128], 64'hFEDC_BA98_7654_3210);
        step();
        b_regwrite = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
